// File: rtl/cardinal_nic.sv
// cardinal_nic: one-entry CPU<->router network interface, one buffer per direction.
// Optional macro NIC_POLARITY_CHECK_EN gates net_so on the router VC polarity.
module cardinal_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    logic [0:DATA_WIDTH-1] r_in_buf;
    logic [0:DATA_WIDTH-1] r_out_buf;
    logic                  r_in_full;
    logic                  r_out_full;

    logic w_eligible;
    logic w_cpu_rd_in;
    logic w_cpu_wr_out;
    logic w_net_rx;
    logic w_net_tx;

`ifdef NIC_POLARITY_CHECK_EN
    // bit 0 of the packet carries its virtual channel
    assign w_eligible = (r_out_buf[0] == net_polarity);
`else
    // polarity is not consulted in this build
    assign w_eligible = net_polarity | 1'b1;
`endif

    assign net_ri = !r_in_full;
    assign net_so = r_out_full && w_eligible;
    assign net_do = r_out_buf;

    assign w_cpu_rd_in  = nicEn && !nicWrEn && (addr == 2'b00) && r_in_full;
    assign w_cpu_wr_out = nicEn && nicWrEn && (addr == 2'b10) && !r_out_full;
    assign w_net_rx     = net_si && net_ri;
    assign w_net_tx     = net_so && net_ro;

    always_comb begin
        d_out = '0;
        if (nicEn) begin
            unique case (addr)
                2'b00: d_out = r_in_buf;
                2'b01: d_out[DATA_WIDTH-1] = r_in_full;
                2'b10: d_out = r_out_buf;
                2'b11: d_out[DATA_WIDTH-1] = r_out_full;
            endcase
        end
    end

    // input path: full and empty conditions make rx and CPU drain exclusive
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_buf  <= '0;
            r_in_full <= 1'b0;
        end else if (w_net_rx) begin
            r_in_buf  <= net_di;
            r_in_full <= 1'b1;
        end else if (w_cpu_rd_in) begin
            r_in_full <= 1'b0;
        end
    end

    // output path: a write landing on the draining edge is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
        end else if (w_cpu_wr_out) begin
            r_out_buf  <= d_in;
            r_out_full <= 1'b1;
        end else if (w_net_tx) begin
            r_out_full <= 1'b0;
        end
    end

endmodule
